// File: rtl/register_file.sv
`default_nettype none
// ============================================================================
// Module   : register_file
// Purpose  : 32 x 32-bit register file with two combinational read ports
//            and one write port. x0 reads as zero. After reset, a 31-cycle
//            clear sequence initialises x1..x31, with x2 = SP_INIT and
//            x3 = GP_INIT. Writes are accepted only once ready is high.
// Options  : define REGFILE_BYPASS_EN to forward write data to a read port
//            that addresses the register being written in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module register_file #(
    parameter logic [31:0] SP_INIT = 32'h0000_03FC,
    parameter logic [31:0] GP_INIT = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [4:0]  rd,
    input  logic [31:0] wd,
    input  logic        we,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    output logic        ready,
    output logic        wr_ack
);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam logic [4:0] C_IDX_FIRST = 5'd1;
    localparam logic [4:0] C_IDX_LAST  = 5'd31;
    localparam logic [4:0] C_SP_IDX    = 5'd2;
    localparam logic [4:0] C_GP_IDX    = 5'd3;
    localparam logic [4:0] C_ZERO_IDX  = 5'd0;

    state_t      r_state_q;
    state_t      w_state_d;
    logic [4:0]  r_idx_q;
    logic [4:0]  w_idx_d;
    logic        r_ready_q;
    logic        w_ready_d;
    logic        r_wr_ack_q;
    logic        w_wr_ack_d;

    // Single write port shared by the clear sequence and normal writes
    logic        w_wr_en;
    logic [4:0]  w_wr_addr;
    logic [31:0] w_wr_data;

    // x0 is hardwired to zero and therefore has no storage
    logic [31:0] r_x_q [31:1];

    // Next-state, clear sequencing and write-port selection
    always_comb begin
        w_state_d  = r_state_q;
        w_idx_d    = r_idx_q;
        w_wr_ack_d = 1'b0;
        w_wr_en    = 1'b0;
        w_wr_addr  = r_idx_q;
        w_wr_data  = 32'h0;
        case (r_state_q)
            ST_CLEAR: begin
                // One register per cycle; user writes are ignored here
                w_wr_en   = 1'b1;
                w_wr_addr = r_idx_q;
                if (r_idx_q == C_SP_IDX) begin
                    w_wr_data = SP_INIT;
                end else if (r_idx_q == C_GP_IDX) begin
                    w_wr_data = GP_INIT;
                end else begin
                    w_wr_data = 32'h0;
                end
                if (r_idx_q == C_IDX_LAST) begin
                    w_state_d = ST_RUN;
                end else begin
                    w_idx_d = r_idx_q + 5'd1;
                end
            end
            ST_RUN: begin
                // Writes to x0 are dropped and never acknowledged
                w_wr_en    = we && (rd != C_ZERO_IDX);
                w_wr_addr  = rd;
                w_wr_data  = wd;
                w_wr_ack_d = we && (rd != C_ZERO_IDX);
            end
            default: begin
                w_state_d = ST_CLEAR;
                w_idx_d   = C_IDX_FIRST;
            end
        endcase
        w_ready_d = (w_state_d == ST_RUN);
    end

    // Control state with asynchronous reset back into the clear sequence
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q  <= ST_CLEAR;
            r_idx_q    <= C_IDX_FIRST;
            r_ready_q  <= 1'b0;
            r_wr_ack_q <= 1'b0;
        end else begin
            r_state_q  <= w_state_d;
            r_idx_q    <= w_idx_d;
            r_ready_q  <= w_ready_d;
            r_wr_ack_q <= w_wr_ack_d;
        end
    end

    // Register storage has no reset; the clear sequence initialises it
    always_ff @(posedge clk) begin
        if (w_wr_en && (w_wr_addr != C_ZERO_IDX)) begin
            r_x_q[w_wr_addr] <= w_wr_data;
        end
    end

    // Combinational read ports, x0 forced to zero, optional forwarding
    always_comb begin
        rd1 = (rs1 == C_ZERO_IDX) ? 32'h0 : r_x_q[rs1];
        rd2 = (rs2 == C_ZERO_IDX) ? 32'h0 : r_x_q[rs2];
`ifdef REGFILE_BYPASS_EN
        if ((r_state_q == ST_RUN) && we && (rd != C_ZERO_IDX) && (rs1 == rd)) begin
            rd1 = wd;
        end
        if ((r_state_q == ST_RUN) && we && (rd != C_ZERO_IDX) && (rs2 == rd)) begin
            rd2 = wd;
        end
`else
        // Without forwarding, a written value becomes visible the next cycle
`endif
    end

    assign ready  = r_ready_q;
    assign wr_ack = r_wr_ack_q;

endmodule
`default_nettype wire

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameter: SP_INIT, default 32'h0000_03FC, value loaded into x2 (sp) by the clear sequence.
REQ-002 Parameter: GP_INIT, default 32'h0000_0000, value loaded into x3 (gp) by the clear sequence.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 rs1  input  5  read address port 1.
REQ-006 rs2  input  5  read address port 2.
REQ-007 rd  input  5  write address.
REQ-008 wd  input  32  write data, the selected write-back value.
REQ-009 we  input  1  write enable.
REQ-010 rd1  output  32  read data port 1.
REQ-011 rd2  output  32  read data port 2.
REQ-012 ready  output  1  high when the clear sequence is complete and writes are accepted.
REQ-013 wr_ack  output  1  registered, high for one cycle after an accepted write to a nonzero rd.

Function
REQ-014 Storage SHALL be 32 registers x 32 bits, x1..x31 in flops, x0 not stored.
REQ-015 Reads SHALL be combinational: rd1 = x[rs1], rd2 = x[rs2], both ports independent.
REQ-016 Reads of x0 SHALL return 32'h0 on either port regardless of any write.
REQ-017 State machine SHALL have states CLEAR and RUN; reset enters CLEAR with index counter = 1.
REQ-018 In CLEAR, each cycle SHALL write one register: x[idx] <= SP_INIT if idx=2, GP_INIT if idx=3, else 0; idx increments.
REQ-019 CLEAR SHALL transition to RUN on the cycle idx=31 is written; clear takes exactly 31 cycles after rst deasserts.
REQ-020 ready SHALL be 0 in CLEAR and 1 in RUN.
REQ-021 In CLEAR, we SHALL be ignored and wr_ack SHALL stay 0; reads SHALL return current (partially cleared) contents.
REQ-022 In RUN, when we=1 and rd!=0, x[rd] SHALL be updated with wd at the rising edge; wr_ack=1 on the following cycle.
REQ-023 In RUN, we=1 with rd=0 SHALL change no state and SHALL NOT assert wr_ack.
REQ-024 A write and a read to the same address in the same cycle SHALL return the old value unless bypass is enabled (REQ-030).
REQ-025 Back-to-back writes SHALL be accepted every cycle; the last write to an address wins.

Reset
REQ-026 Asserting rst at any time, including mid-CLEAR, SHALL immediately force state=CLEAR, idx=1, ready=0, wr_ack=0.
REQ-027 Register contents SHALL NOT be reset asynchronously; they are initialised only by the CLEAR sequence.
REQ-028 Before the first CLEAR completes, read values of not-yet-cleared registers are undefined and SHALL NOT be checked.

Configuration
REQ-029 Macro REGFILE_BYPASS_EN selects write-to-read forwarding.
REQ-030 With REGFILE_BYPASS_EN defined: in RUN, if we=1, rd!=0 and rsN=rd, rdN SHALL equal wd in the same cycle.
REQ-031 Without REGFILE_BYPASS_EN: rdN SHALL show the stored value; the new value appears the cycle after the write.

Verification
REQ-032 Release rst, hold we=1 rd=5 wd=1 -> ready rises after 31 cycles; x2=32'h3FC, x3=0, x5=0 (write ignored), wr_ack never 1 during CLEAR.
REQ-033 In RUN, write rd=0 wd=32'hDEADBEEF, then rs1=0 -> rd1=0, wr_ack=0.
REQ-034 In RUN, write rd=7 wd=32'h12345678, rs1=rs2=7 same cycle -> with REGFILE_BYPASS_EN both read 32'h12345678 immediately; without it, old value then 32'h12345678 next cycle; wr_ack=1 one cycle after.
REQ-035 Writes rd=9 wd=1 then rd=9 wd=2 on consecutive cycles -> x9=2, wr_ack high two consecutive cycles.
REQ-036 Assert rst at CLEAR cycle 10 for one cycle -> ready=0, clear restarts, ready rises 31 cycles after release.
REQ-037 Write all x1..x31 with value=index, read every pair via rs1/rs2 -> each port returns its index, x0 returns 0.
